seg_scan_arbiter: RTL and testbench
===================================

Name: seg_scan_arbiter

Overview:
- Owns the shared 8-bit segment bus (uo_out) and the two digit-common lines (uio_out[1:0]) of the dice display.
- Time-multiplexes the ones and tens digits, with dead-time blanking between them.
- Arbitrates each frame between two sources:
  - the dice-roll result (BCD digits);
  - a raw segment-pattern override written over I2C.
- Applies the board polarity straps: segment polarity from uio_in[6], common polarity from uio_in[7].

Parameters:
- SCAN_CYCLES, 1000, clock cycles each digit is driven (lit phase); must be ≥ 2.
- DEAD_CYCLES, 16, clock cycles of all-off blanking after each lit phase; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design selected; low holds the scanner idle
- seg_pol  in  1  1 = segment lit when high (strap uio_in[6])
- com_pol  in  1  1 = common active when high (strap uio_in[7])
- blank_lz  in  1  1 = blank the tens digit when it is 0
- digit1  in  4  roll result, ones (BCD)
- digit10  in  4  roll result, tens (BCD)
- ovr_en  in  1  I2C override enable
- ovr_seg1  in  8  raw lit-pattern for the ones digit (active-high)
- ovr_seg10  in  8  raw lit-pattern for the tens digit (active-high)
- seg  out  8  segment bus, polarity applied (to uo_out)
- com  out  2  [0] ones common, [1] tens common, polarity applied
- com_oe  out  2  output enables for the commons (to uio_oe[1:0])
- frame_start  out  1  one-cycle pulse when a new frame is latched

Behaviour:
- FSM states and durations:
  - SHOW1: SCAN_CYCLES cycles, then → DEAD1.
  - DEAD1: DEAD_CYCLES cycles, then → SHOW10.
  - SHOW10: SCAN_CYCLES cycles, then → DEAD10.
  - DEAD10: DEAD_CYCLES cycles, then → SHOW1.
- Phase counter: counts 0..N-1 within each state and clears on every transition.
- Reset state: DEAD10 with counter 0. The first SHOW1 therefore starts DEAD_CYCLES cycles after rst_n deasserts.
- Reset values (internal): lit pattern 0; both commons inactive; frame_start 0.
- Reset values (ports):
  - seg = seg_pol ? 8'h00 : 8'hFF;
  - com = com_pol ? 2'b00 : 2'b11;
  - com_oe = 2'b00.
- Frame latch, on the DEAD10→SHOW1 edge only:
  - Samples ovr_en, the two digit patterns and blank_lz; frame_start pulses in the first SHOW1 cycle.
  - Source and digit changes between latches are ignored, so there is no tearing within a frame.
- Roll-source decode, patterns bit[6:0] = g..a, bit7 (DP) = 0:
  - 0 → 3F, 1 → 06, 2 → 5B, 3 → 4F, 4 → 66, 5 → 6D, 6 → 7D, 7 → 07, 8 → 7F, 9 → 6F.
  - 10–14 → 40 (dash); 15 → 00 (blank).
  - Tens digit 0 with latched blank_lz = 1 → 00.
- Override source: ovr_seg1 and ovr_seg10 are used verbatim. blank_lz does not apply.
- Output registers:
  - seg, com and com_oe are registered and change on the same edge as the state.
  - The lit pattern is non-zero only in SHOW1/SHOW10; the DEAD states drive all-off.
  - com[0] is active only in SHOW1; com[1] is active only in SHOW10. The two commons are never active together.
  - com_oe = 2'b11 whenever ena = 1.
- Polarity straps seg_pol and com_pol are applied combinationally at the output XOR stage and take effect immediately.
- ena low (synchronous):
  - next edge forces state DEAD10, counter 0, all-off outputs, com_oe = 00;
  - on ena rising, behaviour is identical to leaving reset.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously).

Decomposition:
- Shared package `dice_pkg`:
  - state enum (SHOW1, DEAD1, SHOW10, DEAD10);
  - the BCD→segment constant table and the SEG_BLANK / SEG_DASH constants.
- Sub-module `seg_decode`: purely combinational 4-bit→8-bit decode. It is instantiated twice, once per latched digit.
- Counter width is $clog2(max(SCAN_CYCLES, DEAD_CYCLES)).

Test Plan (SCAN_CYCLES=8, DEAD_CYCLES=2, seg_pol=1, com_pol=0):
- Reset then release, digit1=7, digit10=4 → after 2 cycles com=2'b10 and seg=07 for 8 cycles; then 2 cycles of com=11, seg=00; then com=2'b01, seg=66. frame_start pulses once every 20 cycles.
- digit10=0, blank_lz=1 → SHOW10 drives seg=00 with com[1] active. With blank_lz=0 → SHOW10 drives seg=3F.
- Mid-SHOW1, set ovr_en=1, ovr_seg1=8'h55 → current frame keeps the roll patterns; the next SHOW1 drives seg=55.
- Toggle seg_pol=0 and com_pol=1 during SHOW1 with digit 1 → seg=F9 and com=2'b01 in the same cycle.
- Digit values 12 and 15 → seg=40 and seg=00 respectively.
- Drop ena for 3 cycles mid-SHOW10 → com_oe=00 and all-off outputs. Re-enable → SHOW1 follows after exactly 2 cycles. At no cycle are both commons active.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: shared scan states, frame snapshot type and seven-segment constants.
package dice_pkg;
  typedef enum logic [1:0] {SHOW1, DEAD1, SHOW10, DEAD10} state_t;
  typedef struct packed {
    logic       ovr_en;
    logic       blank_lz;
    logic [3:0] d1;
    logic [3:0] d10;
    logic [7:0] ovr1;
    logic [7:0] ovr10;
  } frame_t;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  // Index 15 is blank, 10..14 are dashes; bit order is dp,g..a.
  localparam logic [15:0][7:0] SEG_TABLE = {SEG_BLANK, {5{SEG_DASH}},
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational BCD digit to active-high segment pattern.
module seg_decode
  import dice_pkg::*;
(
  input  logic [3:0] d,
  output logic [7:0] seg
);
  assign seg = SEG_TABLE[d];
endmodule

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two-digit display scanner with dead-time blanking and
// per-frame selection between the roll result and a raw override pattern.
module seg_scan_arbiter
  import dice_pkg::*;
#(
  parameter int SCAN_CYCLES = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       seg_pol,
  input  logic       com_pol,
  input  logic       blank_lz,
  input  logic [3:0] digit1,
  input  logic [3:0] digit10,
  input  logic       ovr_en,
  input  logic [7:0] ovr_seg1,
  input  logic [7:0] ovr_seg10,
  output logic [7:0] seg,
  output logic [1:0] com,
  output logic [1:0] com_oe,
  output logic       frame_start
);
  localparam int CW = $clog2(SCAN_CYCLES > DEAD_CYCLES ? SCAN_CYCLES : DEAD_CYCLES);
  state_t state_q, state_d;
  frame_t frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] lit_q, lit_d, dec1, dec10;
  logic [1:0] act_q, act_d, oe_q, oe_d;
  logic fs_q, fs_d, show, last, latch;
  // Decoders look at the frame being latched so patterns update on the same edge as the state.
  seg_decode u_dec1  (.d(frame_d.d1),  .seg(dec1));
  seg_decode u_dec10 (.d(frame_d.d10), .seg(dec10));
  always_comb begin
    show    = state_q == SHOW1 || state_q == SHOW10;
    last    = cnt_q == (show ? CW'(SCAN_CYCLES - 1) : CW'(DEAD_CYCLES - 1));
    latch   = ena && last && state_q == DEAD10;
    frame_d = latch ? {ovr_en, blank_lz, digit1, digit10, ovr_seg1, ovr_seg10} : frame_q;
    state_d = !ena ? DEAD10 : !last ? state_q : state_t'(state_q + 2'd1);
    cnt_d   = ena && !last ? cnt_q + 1'b1 : '0;
    lit_d   = state_d == SHOW1  ? (frame_d.ovr_en ? frame_d.ovr1 : dec1) :
              state_d == SHOW10 ? (frame_d.ovr_en ? frame_d.ovr10 :
                                   frame_d.blank_lz && frame_d.d10 == 4'd0 ? SEG_BLANK : dec10) :
              SEG_BLANK;
    act_d   = {state_d == SHOW10, state_d == SHOW1};
    oe_d    = {2{ena}};
    fs_d    = latch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEAD10;
      cnt_q   <= '0;
      frame_q <= '0;
      lit_q   <= '0;
      act_q   <= '0;
      oe_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      lit_q   <= lit_d;
      act_q   <= act_d;
      oe_q    <= oe_d;
      fs_q    <= fs_d;
    end
  end
  assign seg         = lit_q ^ {8{~seg_pol}};
  assign com         = act_q ^ {2{~com_pol}};
  assign com_oe      = oe_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: scoreboard bench; a frame-position model pushes the
// expected raw outputs each edge and the scenario tasks pop and compare them.
module tb_seg_scan_arbiter;
  logic clk = 0, rst_n = 1, ena = 1, seg_pol = 1, com_pol = 0, blank_lz = 0, ovr_en = 0;
  logic [3:0] digit1 = 4'd7, digit10 = 4'd4;
  logic [7:0] ovr_seg1 = 0, ovr_seg10 = 0;
  logic [7:0] seg;
  logic [1:0] com, com_oe;
  logic frame_start;
  int tests = 0, fails = 0;

  seg_scan_arbiter #(.SCAN_CYCLES(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_pol(seg_pol), .com_pol(com_pol),
    .blank_lz(blank_lz), .digit1(digit1), .digit10(digit10), .ovr_en(ovr_en),
    .ovr_seg1(ovr_seg1), .ovr_seg10(ovr_seg10), .seg(seg), .com(com),
    .com_oe(com_oe), .frame_start(frame_start));

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] lit; logic [1:0] act; logic [1:0] oe; logic fs;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int m_pos = 18;
  logic f_ovr, f_blk;
  logic [3:0] f_d1, f_d10;
  logic [7:0] f_o1, f_o10;
  logic [12:0] got;
  assign got = {seg, com, com_oe, frame_start};

  function automatic logic [7:0] tb_dec(input logic [3:0] d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; 9: return 8'h6F;
      15: return 8'h00;
      default: return 8'h40;
    endcase
  endfunction

  function automatic logic [12:0] want(input exp_t e);
    return {e.lit ^ {8{~seg_pol}}, e.act ^ {2{~com_pol}}, e.oe, e.fs};
  endfunction

  // Frame positions: 0..7 ones lit, 8..9 dead, 10..17 tens lit, 18..19 dead.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 18;
      q.delete();
    end else begin
      if (!ena) m_pos = 18;
      else begin
        m_pos = (m_pos + 1) % 20;
        if (m_pos == 0) begin
          f_ovr = ovr_en; f_blk = blank_lz; f_d1 = digit1; f_d10 = digit10;
          f_o1 = ovr_seg1; f_o10 = ovr_seg10;
        end
      end
      m_e.fs  = ena && m_pos == 0;
      m_e.oe  = ena ? 2'b11 : 2'b00;
      m_e.act = m_pos < 8 ? 2'b01 : (m_pos >= 10 && m_pos < 18) ? 2'b10 : 2'b00;
      m_e.lit = m_pos < 8 ? (f_ovr ? f_o1 : tb_dec(f_d1)) :
                (m_pos >= 10 && m_pos < 18) ? (f_ovr ? f_o10 : (f_blk && f_d10 == 0) ? 8'h00 : tb_dec(f_d10)) :
                8'h00;
      q.push_back(m_e);
    end
  end

  task automatic test_reset;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    tests += 4;
    if (seg !== 8'h00) begin fails++; $display("FAIL reset_seg: got %h want 00", seg); end
    if (com !== 2'b11) begin fails++; $display("FAIL reset_com: got %b want 11", com); end
    if (com_oe !== 2'b00) begin fails++; $display("FAIL reset_oe: got %b want 00", com_oe); end
    if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    seg_pol = 0; com_pol = 1; #1;
    tests += 2;
    if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg_inv: got %h want FF", seg); end
    if (com !== 2'b00) begin fails++; $display("FAIL reset_com_inv: got %b want 00", com); end
    seg_pol = 1; com_pol = 0;
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_roll_scan;
    exp_t e;
    int pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk); #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL roll: got %h want %h at pos %0d", got, want(e), m_pos); end
      if (i < 40 && frame_start) pulses++;
      if (m_pos == 3) begin tests++; if ({seg, com} !== {8'h07, 2'b10}) begin fails++; $display("FAIL roll_ones: got %h/%b want 07/10", seg, com); end end
      if (m_pos == 9) begin tests++; if ({seg, com} !== {8'h00, 2'b11}) begin fails++; $display("FAIL roll_dead: got %h/%b want 00/11", seg, com); end end
      if (m_pos == 12) begin tests++; if ({seg, com} !== {8'h66, 2'b01}) begin fails++; $display("FAIL roll_tens: got %h/%b want 66/01", seg, com); end end
    end
    tests++;
    if (pulses != 2) begin fails++; $display("FAIL frame_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_blank_lz;
    exp_t e;
    digit10 = 0; blank_lz = 1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (i == 45) blank_lz = 0;
      #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL blank_lz: got %h want %h at pos %0d", got, want(e), m_pos); end
      if (i >= 20 && i < 45 && m_pos == 12) begin tests++; if ({seg, com} !== {8'h00, 2'b01}) begin fails++; $display("FAIL blank_on: got %h/%b want 00/01", seg, com); end end
      if (i >= 65 && m_pos == 12) begin tests++; if ({seg, com} !== {8'h3F, 2'b01}) begin fails++; $display("FAIL blank_off: got %h/%b want 3F/01", seg, com); end end
    end
  endtask

  task automatic test_override;
    exp_t e;
    bit fired = 0, z = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!fired && m_pos == 3) begin ovr_en = 1; ovr_seg1 = 8'h55; ovr_seg10 = 8'hAA; fired = 1; end
      else if (fired && m_pos == 0) z = 1;
      #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL override: got %h want %h at pos %0d", got, want(e), m_pos); end
      if (fired && !z && m_pos == 12) begin tests++; if (seg !== 8'h3F) begin fails++; $display("FAIL ovr_no_tear: got %h want 3F", seg); end end
      if (z && m_pos == 5) begin tests++; if (seg !== 8'h55) begin fails++; $display("FAIL ovr_applied: got %h want 55", seg); end end
    end
    tests++;
    if (!z) begin fails++; $display("FAIL ovr_timeout: got no frame want one"); end
    ovr_en = 0;
  endtask

  task automatic test_polarity;
    exp_t e;
    bit fired = 0;
    digit1 = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!fired && i >= 25 && m_pos == 2) begin seg_pol = 0; com_pol = 1; fired = 1; end
      #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL polarity: got %h want %h at pos %0d", got, want(e), m_pos); end
      if (fired && m_pos == 2 && seg_pol == 0) begin
        tests++;
        if ({seg, com} !== {8'hF9, 2'b01}) begin fails++; $display("FAIL pol_same_cycle: got %h/%b want F9/01", seg, com); end
        seg_pol = 1; com_pol = 0;
      end
    end
    seg_pol = 1; com_pol = 0;
  endtask

  task automatic test_dash_blank;
    exp_t e;
    digit1 = 12; digit10 = 15;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk); #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL dash_blank: got %h want %h at pos %0d", got, want(e), m_pos); end
      if (i >= 20 && m_pos == 4) begin tests++; if (seg !== 8'h40) begin fails++; $display("FAIL dash: got %h want 40", seg); end end
      if (i >= 20 && m_pos == 14) begin tests++; if ({seg, com} !== {8'h00, 2'b01}) begin fails++; $display("FAIL digit_blank: got %h/%b want 00/01", seg, com); end end
    end
  endtask

  task automatic test_ena_drop;
    exp_t e;
    bit fired = 0;
    int k = 0, i_en = -1;
    digit1 = 3; digit10 = 8;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!fired && i >= 20 && m_pos == 12) begin ena = 0; fired = 1; k = 3; end
      else if (k > 0) begin k--; if (k == 0) begin ena = 1; i_en = i; end end
      #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL ena_drop: got %h want %h at pos %0d", got, want(e), m_pos); end
      tests++;
      if ((com ^ {2{~com_pol}}) == 2'b11) begin fails++; $display("FAIL both_commons: got com=%b want one inactive", com); end
      if (k == 1) begin tests++; if ({seg, com, com_oe} !== {8'h00, 2'b11, 2'b00}) begin fails++; $display("FAIL ena_off: got %h/%b/%b want 00/11/00", seg, com, com_oe); end end
      if (i_en >= 0 && i == i_en + 2) begin tests++; if ({seg, com, frame_start} !== {8'h4F, 2'b10, 1'b1}) begin fails++; $display("FAIL ena_resume: got %h/%b/%b want 4F/10/1", seg, com, frame_start); end end
    end
    tests++;
    if (i_en < 0) begin fails++; $display("FAIL ena_timeout: got no re-enable want one"); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    for (int i = 0; i < 25 && m_pos != 4; i++) begin
      @(negedge clk); #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL pre_reset: got %h want %h", got, want(e)); end
    end
    #2 rst_n = 0; #1;
    tests++;
    if (got !== {8'h00, 2'b11, 2'b00, 1'b0}) begin fails++; $display("FAIL async_reset: got %h want %h", got, {8'h00, 2'b11, 2'b00, 1'b0}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      e = q.size() ? q.pop_front() : exp_t'('1); tests++;
      if (got !== want(e)) begin fails++; $display("FAIL post_reset: got %h want %h at pos %0d", got, want(e), m_pos); end
    end
  endtask

  initial begin
    test_reset;
    test_roll_scan;
    test_blank_lz;
    test_override;
    test_polarity;
    test_dash_blank;
    test_ena_drop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
